target_uart_trigger: RTL and testbench

- Deserializes the target's UART TX line (target_rx) and fires a one-cycle trigger when a programmed byte arrives while the block is armed.
- The trigger drives the offset counter's enable, so glitch timing is referenced to a target output byte (e.g. a bootloader prompt) rather than to the host command.
- Sits between the target_rx pin and offset_counter, in the sys_clk domain alongside command_processor, which supplies arm and match_byte.

---
 rtl/target_uart_trigger.sv | 192 +++++++++++++++++++
 tb/tb_target_uart_trigger.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/target_uart_trigger.sv
`default_nettype none
// ============================================================================
// Module   : target_uart_trigger
// Brief    : Target UART RX deserializer; one-shot trigger on a programmed byte.
//            Optional macro TARGET_TRIG_COUNT_EN adds match_count (Nth-match).
// Revision : 1.0
// ============================================================================
module target_uart_trigger #(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_W        = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       arm,
    input  logic [7:0] match_byte,
`ifdef TARGET_TRIG_COUNT_EN
    input  logic [7:0] match_count,
`endif
    output logic       trigger,
    output logic       armed,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] c_bit_last = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] c_half     = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

    logic             rx_meta_q, rxs_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             trigger_q, trigger_d;
    logic             armed_q, armed_d;
    logic             w_good_stop, w_match;
`ifdef TARGET_TRIG_COUNT_EN
    logic [7:0]       occ_q, occ_d;
`endif

    // rx idles high, so the synchronizer resets to 1 to avoid a false start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            trigger_q   <= 1'b0;
            armed_q     <= 1'b0;
`ifdef TARGET_TRIG_COUNT_EN
            occ_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            trigger_q   <= trigger_d;
            armed_q     <= armed_d;
`ifdef TARGET_TRIG_COUNT_EN
            occ_q       <= occ_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        w_good_stop = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!rxs_q) begin
                    cnt_d   = c_half;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == '0) begin
                    if (!rxs_q) begin
                        cnt_d   = c_bit_last;
                        bit_d   = 3'd0;
                        state_d = S_DATA;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - c_one;
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rxs_q, shift_q[7:1]};
                    cnt_d   = c_bit_last;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - c_one;
                end
            end
            S_STOP: begin
                if (cnt_q == '0) begin
                    if (rxs_q) begin
                        w_good_stop = 1'b1;
                        rx_data_d   = shift_q;
                        rx_valid_d  = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q - c_one;
                end
            end
            S_WAIT_HIGH: begin
                if (rxs_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        w_match = w_good_stop && (shift_q == match_byte);

        // Match uses the pre-update armed value; a same-cycle arm still wins.
`ifdef TARGET_TRIG_COUNT_EN
        occ_d     = occ_q;
        trigger_d = armed_q && w_match && (occ_q == 8'd0);
        if (armed_q && w_match && (occ_q != 8'd0)) begin
            occ_d = occ_q - 8'd1;
        end
        if (arm) begin
            occ_d = match_count;
        end
`else
        trigger_d = armed_q && w_match;
`endif
        armed_d = armed_q;
        if (trigger_d) begin
            armed_d = 1'b0;
        end
        if (arm) begin
            armed_d = 1'b1;
        end
    end

    assign trigger   = trigger_q;
    assign armed     = armed_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_target_uart_trigger.sv
`default_nettype none
// ============================================================================
// Module   : tb_target_uart_trigger
// Brief    : Frame-level reference model bench for target_uart_trigger.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_target_uart_trigger;

    localparam int CPB = 16;
    localparam int LAT = 155;  // 2 sync + 9.5*CPB + 1 register

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       arm = 1'b0;
    logic [7:0] match_byte = 8'h3E;
`ifdef TARGET_TRIG_COUNT_EN
    logic [7:0] match_count = 8'd0;
    int         occ_m = 0;
`endif
    logic       trigger, armed, rx_valid, frame_err;
    logic [7:0] rx_data;

    target_uart_trigger #(.CLKS_PER_BIT(CPB), .CNT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .arm        (arm),
        .match_byte (match_byte),
`ifdef TARGET_TRIG_COUNT_EN
        .match_count(match_count),
`endif
        .trigger    (trigger),
        .armed      (armed),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0, n_valid = 0, n_trig = 0, n_ferr = 0, n_solo = 0, last_valid_cyc = 0;
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rx_valid) begin
            n_valid        <= n_valid + 1;
            last_valid_cyc <= cyc;
        end
        if (trigger)             n_trig <= n_trig + 1;
        if (frame_err)           n_ferr <= n_ferr + 1;
        if (trigger && !rx_valid) n_solo <= n_solo + 1;
    end

    int         n_checks = 0, n_errors = 0;
    bit         armed_m = 1'b0;
    logic [7:0] last_m = 8'h00;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
        end
    endtask

    task automatic pulse_arm();
        @(negedge clk); arm = 1'b1;
        @(negedge clk); arm = 1'b0;
        armed_m = 1'b1;
`ifdef TARGET_TRIG_COUNT_EN
        occ_m = match_count;
`endif
    endtask

    task automatic run_frame(input logic [7:0] b, input bit good, input bit arm_stop, input int low_hold);
        int  v0, sv, st, sf, ss, lat;
        bit  hit, fire;
        sv = n_valid; st = n_trig; sf = n_ferr; ss = n_solo;
        @(negedge clk); rx = 1'b0; v0 = cyc;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            rx = b[i];
        end
        repeat (CPB) @(negedge clk);
        rx = good;
        // arm lands on the cycle of the stop-bit sample when arm_stop is set
        for (int i = 0; i < CPB; i++) begin
            @(negedge clk);
            if (arm_stop) arm = (i == 9);
        end
        if (!good) begin
            repeat (low_hold) @(negedge clk);
            rx = 1'b1;
        end
        repeat (8) @(negedge clk);
        #1;
        hit  = good && (b == match_byte);
        fire = armed_m && hit;
`ifdef TARGET_TRIG_COUNT_EN
        fire = fire && (occ_m == 0);
        if (armed_m && hit && occ_m != 0) occ_m--;
`endif
        if (fire) armed_m = 1'b0;
        if (arm_stop) begin
            armed_m = 1'b1;
`ifdef TARGET_TRIG_COUNT_EN
            occ_m = match_count;
`endif
        end
        if (good) last_m = b;
        chk("valid_cnt", n_valid - sv, good ? 1 : 0);
        chk("trig_cnt", n_trig - st, fire ? 1 : 0);
        chk("ferr_cnt", n_ferr - sf, good ? 0 : 1);
        chk("trig_solo", n_solo - ss, 0);
        chk("rx_data", int'(rx_data), int'(last_m));
        chk("armed", int'(armed), int'(armed_m));
        if (good) begin
            lat = last_valid_cyc - v0;
            chk("latency", (lat >= LAT - 1 && lat <= LAT + 1) ? LAT : lat, LAT);
        end
    endtask

    task automatic quiet_window(input string tag, input int cycles);
        int sv, st, sf;
        sv = n_valid; st = n_trig; sf = n_ferr;
        repeat (cycles) @(negedge clk);
        #1;
        chk({tag, "_valid"}, n_valid - sv, 0);
        chk({tag, "_trig"}, n_trig - st, 0);
        chk({tag, "_ferr"}, n_ferr - sf, 0);
        chk({tag, "_armed"}, int'(armed), int'(armed_m));
    endtask

    task automatic glitch();
        @(negedge clk); rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        quiet_window("glitch", 200);
    endtask

    task automatic reset_mid_frame(input logic [7:0] b);
        @(negedge clk); rx = 1'b0;
        for (int i = 0; i < 5; i++) begin
            repeat (CPB) @(negedge clk);
            rx = b[i];
        end
        repeat (CPB / 2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_armed", int'(armed), 0);
        chk("rstmid_valid", int'(rx_valid), 0);
        chk("rstmid_trig", int'(trigger), 0);
        chk("rstmid_ferr", int'(frame_err), 0);
        chk("rstmid_data", int'(rx_data), 0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        armed_m = 1'b0;
        last_m  = 8'h00;
`ifdef TARGET_TRIG_COUNT_EN
        occ_m = 0;
`endif
        quiet_window("rstmid", 200);
    endtask

    initial begin
        bit         good, arm_stop;
        logic [7:0] b;

        repeat (5) @(negedge clk);
        #1;
        chk("rst_trig", int'(trigger), 0);
        chk("rst_armed", int'(armed), 0);
        chk("rst_data", int'(rx_data), 0);
        chk("rst_valid", int'(rx_valid), 0);
        chk("rst_ferr", int'(frame_err), 0);
        @(negedge clk); rst = 1'b0;
        quiet_window("idle", 1000);

        // single match, then the trigger must not re-fire
        pulse_arm();
        run_frame(8'h3E, 1'b1, 1'b0, 0);
        run_frame(8'h3E, 1'b1, 1'b0, 0);
        // non-match then match
        pulse_arm();
        run_frame(8'h55, 1'b1, 1'b0, 0);
        run_frame(8'h3E, 1'b1, 1'b0, 0);
        // frame error keeps armed, next good match fires
        pulse_arm();
        run_frame(8'h3E, 1'b0, 1'b0, 40);
        run_frame(8'h3E, 1'b1, 1'b0, 0);
        // glitch and mid-frame reset
        glitch();
        pulse_arm();
        reset_mid_frame(8'h3E);
        run_frame(8'hA5, 1'b1, 1'b0, 0);
        // arm coincident with a matching stop sample, unarmed then armed
        run_frame(8'h3E, 1'b1, 1'b1, 0);
        run_frame(8'h3E, 1'b1, 1'b1, 0);
        run_frame(8'h3E, 1'b1, 1'b0, 0);
`ifdef TARGET_TRIG_COUNT_EN
        match_count = 8'd2;
        pulse_arm();
        for (int i = 0; i < 3; i++) run_frame(8'h3E, 1'b1, 1'b0, 0);
`endif

        for (int k = 0; k < 30; k++) begin
            if (!armed_m && ($urandom % 3 == 0)) begin
                match_byte = 8'($urandom);
`ifdef TARGET_TRIG_COUNT_EN
                match_count = 8'($urandom % 3);
`endif
            end
            if ($urandom % 3 == 0) pulse_arm();
            b        = ($urandom % 2 == 0) ? match_byte : 8'($urandom);
            good     = ($urandom % 6) != 0;
            arm_stop = ($urandom % 8) == 0;
            run_frame(b, good, arm_stop, $urandom_range(0, 30));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
